neuron_cmd_ctrl: RTL and testbench

Command and event controller that sits directly downstream of `neuron_event_decode`. It synchronises the asynchronous host strobe and captures one decoded event per strobe rising edge. It then forwards tick and spike events to the neuron core as one-cycle pulses and executes the special commands (soft reset, arm, config write) against a small configuration register file. Arming gates both event forwarding and config writes.

---
 rtl/neuron_cmd_ctrl.sv | 256 +++++++++++++++++++++++++
 tb/tb_neuron_cmd_ctrl.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/neuron_cmd_ctrl.sv
// -----------------------------------------------------------------------------
// neuron_cmd_ctrl
//
// Command and event controller placed after neuron_event_decode. The host
// strobe is synchronised with a three-flop chain, and each rising edge
// captures one decoded event. Tick and spike events are forwarded to the
// neuron core as one-cycle pulses, but only while the block is armed.
// Special commands act on a small configuration register file:
//   - soft reset: pulses soft_rst and restores the defaults
//   - arm: sets the armed state
//   - config write: updates one register, and only while disarmed
//
// Optional feature (macro NEURON_DROP_CNT_EN):
//   defined   : drop_cnt counts events dropped while disarmed, saturating at 255
//   undefined : no counter flops are built and drop_cnt is tied to 8'd0
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   ena                 design enable; strobe edges are ignored while low
//   strobe              asynchronous host strobe, one event per rising edge
//   is_tick, polarity   decoded event fields
//   addr[5:0]           decoded neuron address
//   cfg_op[1:0]         config opcode (0/1 threshold nibbles, 2 leak, 3 refrac)
//   cfg_arg[3:0]        config nibble
//   is_reset_cmd, is_arm_cmd, is_cfg_cmd   decoded command flags
//   tick_valid          one-cycle tick pulse
//   spike_valid         one-cycle spike pulse; spike_pol and spike_addr qualify it
//   soft_rst            one-cycle core clear pulse
//   armed               arm state
//   cfg_err             sticky flag: config write attempted while armed
//   cfg_threshold[7:0], cfg_leak[3:0], cfg_refrac[3:0]   config registers
//   drop_cnt[7:0]       saturating count of events dropped while disarmed
// -----------------------------------------------------------------------------
module neuron_cmd_ctrl #(
  parameter logic [7:0] THRESH_RST = 8'd16,
  parameter logic [3:0] LEAK_RST   = 4'd1,
  parameter logic [3:0] REFRAC_RST = 4'd2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic       strobe,
  input  logic       is_tick,
  input  logic       polarity,
  input  logic [5:0] addr,
  input  logic [1:0] cfg_op,
  input  logic [3:0] cfg_arg,
  input  logic       is_reset_cmd,
  input  logic       is_arm_cmd,
  input  logic       is_cfg_cmd,
  output logic       tick_valid,
  output logic       spike_valid,
  output logic       spike_pol,
  output logic [5:0] spike_addr,
  output logic       soft_rst,
  output logic       armed,
  output logic       cfg_err,
  output logic [7:0] cfg_threshold,
  output logic [3:0] cfg_leak,
  output logic [3:0] cfg_refrac,
  output logic [7:0] drop_cnt
);

  // Action selected on a rise cycle; the enum encodes the priority order
  typedef enum logic [2:0] {
    ACT_NONE  = 3'd0,
    ACT_RESET = 3'd1,
    ACT_ARM   = 3'd2,
    ACT_CFG   = 3'd3,
    ACT_TICK  = 3'd4,
    ACT_SPIKE = 3'd5
  } act_e;

  logic       s1_r, s2_r, s3_r;
  logic [2:0] vld_r;
  logic       rise_s;
  act_e       act_s;

  logic       tick_valid_r,  tick_valid_nxt_s;
  logic       spike_valid_r, spike_valid_nxt_s;
  logic       spike_pol_r,   spike_pol_nxt_s;
  logic [5:0] spike_addr_r,  spike_addr_nxt_s;
  logic       soft_rst_r,    soft_rst_nxt_s;
  logic       armed_r,       armed_nxt_s;
  logic       cfg_err_r,     cfg_err_nxt_s;
  logic [7:0] thresh_r,      thresh_nxt_s;
  logic [3:0] leak_r,        leak_nxt_s;
  logic [3:0] refrac_r,      refrac_nxt_s;

  // Strobe synchroniser plus a post-reset fill tracker for the chain
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_r  <= 1'b0;
      s2_r  <= 1'b0;
      s3_r  <= 1'b0;
      vld_r <= 3'b000;
    end else begin
      s1_r  <= strobe;
      s2_r  <= s1_r;
      s3_r  <= s2_r;
      vld_r <= {vld_r[1:0], 1'b1};
    end
  end

  // The zero left in s3 by reset is not a real low sample. Without vld_r[2],
  // a strobe already high at reset release would look like a fresh edge.
  assign rise_s = s2_r & ~s3_r & ena & vld_r[2];

  // Priority decode of the captured event into exactly one action
  always_comb begin
    act_s = ACT_NONE;
    if (rise_s) begin
      if (is_reset_cmd) begin
        act_s = ACT_RESET;
      end else if (is_arm_cmd) begin
        act_s = ACT_ARM;
      end else if (is_cfg_cmd) begin
        act_s = ACT_CFG;
      end else if (is_tick) begin
        act_s = ACT_TICK;
      end else begin
        act_s = ACT_SPIKE;
      end
    end else begin
      act_s = ACT_NONE;
    end
  end

  // Next-state for pulses, arm/error state, spike payload and config file
  always_comb begin
    tick_valid_nxt_s  = 1'b0;
    spike_valid_nxt_s = 1'b0;
    soft_rst_nxt_s    = 1'b0;
    spike_pol_nxt_s   = spike_pol_r;
    spike_addr_nxt_s  = spike_addr_r;
    armed_nxt_s       = armed_r;
    cfg_err_nxt_s     = cfg_err_r;
    thresh_nxt_s      = thresh_r;
    leak_nxt_s        = leak_r;
    refrac_nxt_s      = refrac_r;
    case (act_s)
      ACT_RESET: begin
        soft_rst_nxt_s = 1'b1;
        armed_nxt_s    = 1'b0;
        cfg_err_nxt_s  = 1'b0;
        thresh_nxt_s   = THRESH_RST;
        leak_nxt_s     = LEAK_RST;
        refrac_nxt_s   = REFRAC_RST;
      end
      ACT_ARM: begin
        armed_nxt_s = 1'b1;
      end
      ACT_CFG: begin
        if (armed_r) begin
          cfg_err_nxt_s = 1'b1;
        end else begin
          case (cfg_op)
            2'd0:    thresh_nxt_s = {thresh_r[7:4], cfg_arg};
            2'd1:    thresh_nxt_s = {cfg_arg, thresh_r[3:0]};
            2'd2:    leak_nxt_s   = cfg_arg;
            2'd3:    refrac_nxt_s = cfg_arg;
            default: thresh_nxt_s = thresh_r;
          endcase
        end
      end
      ACT_TICK: begin
        if (armed_r) begin
          tick_valid_nxt_s = 1'b1;
        end else begin
          tick_valid_nxt_s = 1'b0;
        end
      end
      ACT_SPIKE: begin
        if (armed_r) begin
          spike_valid_nxt_s = 1'b1;
          spike_pol_nxt_s   = polarity;
          spike_addr_nxt_s  = addr;
        end else begin
          spike_valid_nxt_s = 1'b0;
        end
      end
      default: begin
        tick_valid_nxt_s = 1'b0;
      end
    endcase
  end

  // Output and configuration registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_valid_r  <= 1'b0;
      spike_valid_r <= 1'b0;
      spike_pol_r   <= 1'b0;
      spike_addr_r  <= 6'd0;
      soft_rst_r    <= 1'b0;
      armed_r       <= 1'b0;
      cfg_err_r     <= 1'b0;
      thresh_r      <= THRESH_RST;
      leak_r        <= LEAK_RST;
      refrac_r      <= REFRAC_RST;
    end else begin
      tick_valid_r  <= tick_valid_nxt_s;
      spike_valid_r <= spike_valid_nxt_s;
      spike_pol_r   <= spike_pol_nxt_s;
      spike_addr_r  <= spike_addr_nxt_s;
      soft_rst_r    <= soft_rst_nxt_s;
      armed_r       <= armed_nxt_s;
      cfg_err_r     <= cfg_err_nxt_s;
      thresh_r      <= thresh_nxt_s;
      leak_r        <= leak_nxt_s;
      refrac_r      <= refrac_nxt_s;
    end
  end

`ifdef NEURON_DROP_CNT_EN
  logic [7:0] drop_cnt_r, drop_cnt_nxt_s;

  // Drop counter: cleared by reset cmd, saturating increment on disarmed events
  always_comb begin
    drop_cnt_nxt_s = drop_cnt_r;
    if (act_s == ACT_RESET) begin
      drop_cnt_nxt_s = 8'd0;
    end else if (((act_s == ACT_TICK) || (act_s == ACT_SPIKE)) && !armed_r
                 && (drop_cnt_r != 8'hFF)) begin
      drop_cnt_nxt_s = drop_cnt_r + 8'd1;
    end else begin
      drop_cnt_nxt_s = drop_cnt_r;
    end
  end

  // Drop counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_cnt_r <= 8'd0;
    end else begin
      drop_cnt_r <= drop_cnt_nxt_s;
    end
  end

  assign drop_cnt = drop_cnt_r;
`else
  assign drop_cnt = 8'd0;
`endif

  assign tick_valid    = tick_valid_r;
  assign spike_valid   = spike_valid_r;
  assign spike_pol     = spike_pol_r;
  assign spike_addr    = spike_addr_r;
  assign soft_rst      = soft_rst_r;
  assign armed         = armed_r;
  assign cfg_err       = cfg_err_r;
  assign cfg_threshold = thresh_r;
  assign cfg_leak      = leak_r;
  assign cfg_refrac    = refrac_r;

endmodule

// File: tb/tb_neuron_cmd_ctrl.sv
// -----------------------------------------------------------------------------
// tb_neuron_cmd_ctrl
//
// Directed and randomised events for neuron_cmd_ctrl. A small event-level
// reference model predicts the arm/config/error state, the drop count and the
// total number of pulses expected on each pulse output. The expected
// drop_cnt follows NEURON_DROP_CNT_EN.
// -----------------------------------------------------------------------------
module tb_neuron_cmd_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b1;
  logic       strobe = 1'b0;
  logic       is_tick = 1'b0;
  logic       polarity = 1'b0;
  logic [5:0] addr = 6'd0;
  logic [1:0] cfg_op = 2'd0;
  logic [3:0] cfg_arg = 4'd0;
  logic       is_reset_cmd = 1'b0;
  logic       is_arm_cmd = 1'b0;
  logic       is_cfg_cmd = 1'b0;
  logic       tick_valid, spike_valid, spike_pol, soft_rst, armed, cfg_err;
  logic [5:0] spike_addr;
  logic [7:0] cfg_threshold, drop_cnt;
  logic [3:0] cfg_leak, cfg_refrac;

`ifdef NEURON_DROP_CNT_EN
  localparam bit DROP_EN = 1'b1;
`else
  localparam bit DROP_EN = 1'b0;
`endif

  neuron_cmd_ctrl dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .strobe(strobe),
    .is_tick(is_tick), .polarity(polarity), .addr(addr),
    .cfg_op(cfg_op), .cfg_arg(cfg_arg),
    .is_reset_cmd(is_reset_cmd), .is_arm_cmd(is_arm_cmd), .is_cfg_cmd(is_cfg_cmd),
    .tick_valid(tick_valid), .spike_valid(spike_valid), .spike_pol(spike_pol),
    .spike_addr(spike_addr), .soft_rst(soft_rst), .armed(armed), .cfg_err(cfg_err),
    .cfg_threshold(cfg_threshold), .cfg_leak(cfg_leak), .cfg_refrac(cfg_refrac),
    .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  // Count the cycles each pulse output is high, sampled on the falling edge
  int tick_seen = 0, spike_seen = 0, srst_seen = 0;
  always @(negedge clk) begin
    if (tick_valid === 1'b1)  tick_seen  <= tick_seen + 1;
    if (spike_valid === 1'b1) spike_seen <= spike_seen + 1;
    if (soft_rst === 1'b1)    srst_seen  <= srst_seen + 1;
  end

  // Reference model state
  int       n_cmp = 0, n_bad = 0;
  bit       m_armed, m_err, m_pol;
  int       m_thr, m_leak, m_refrac, m_drop, m_addr;
  int       m_tick = 0, m_spike = 0, m_srst = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_hw_reset();
    m_armed = 1'b0; m_err = 1'b0; m_pol = 1'b0; m_addr = 0;
    m_thr = 16; m_leak = 1; m_refrac = 2; m_drop = 0;
  endtask

  // Apply one strobe edge to the model, following the command rules
  task automatic model_event(input bit en, input bit rs, input bit ar,
                             input bit cf, input bit tk, input bit pl,
                             input int ad, input int op, input int arg);
    if (!en) return;
    if (rs) begin
      m_srst++;
      m_armed = 1'b0; m_err = 1'b0;
      m_thr = 16; m_leak = 1; m_refrac = 2; m_drop = 0;
    end else if (ar) begin
      m_armed = 1'b1;
    end else if (cf) begin
      if (m_armed) m_err = 1'b1;
      else if (op == 0) m_thr = (m_thr & 'hF0) | arg;
      else if (op == 1) m_thr = (m_thr & 'h0F) | (arg * 16);
      else if (op == 2) m_leak = arg;
      else m_refrac = arg;
    end else if (!m_armed) begin
      if (DROP_EN && m_drop < 255) m_drop++;
    end else if (tk) begin
      m_tick++;
    end else begin
      m_spike++; m_pol = pl; m_addr = ad;
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".tick_cnt"},  tick_seen,  m_tick);
    chk({tag, ".spike_cnt"}, spike_seen, m_spike);
    chk({tag, ".srst_cnt"},  srst_seen,  m_srst);
    chk({tag, ".spike_pol"}, int'(spike_pol), int'(m_pol));
    chk({tag, ".spike_addr"}, int'(spike_addr), m_addr);
    chk({tag, ".armed"},     int'(armed),   int'(m_armed));
    chk({tag, ".cfg_err"},   int'(cfg_err), int'(m_err));
    chk({tag, ".thresh"},    int'(cfg_threshold), m_thr);
    chk({tag, ".leak"},      int'(cfg_leak),   m_leak);
    chk({tag, ".refrac"},    int'(cfg_refrac), m_refrac);
    chk({tag, ".drop"},      int'(drop_cnt),   m_drop);
  endtask

  // One strobe event, called at a falling edge: fields stable throughout
  task automatic send(input bit rs, input bit ar, input bit cf, input bit tk,
                      input bit pl, input int ad, input int op, input int arg,
                      input int hold);
    is_reset_cmd = rs; is_arm_cmd = ar; is_cfg_cmd = cf; is_tick = tk;
    polarity = pl; addr = 6'(ad); cfg_op = 2'(op); cfg_arg = 4'(arg);
    strobe = 1'b1;
    repeat (hold) @(negedge clk);
    strobe = 1'b0;
    repeat (4) @(negedge clk);
    model_event(ena, rs, ar, cf, tk, pl, ad, op, arg);
  endtask

  initial begin
    model_hw_reset();
    repeat (3) @(negedge clk);
    check_all("reset");
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // Disarmed spike is dropped
    send(0, 0, 0, 0, 1, 5, 0, 0, 2);
    check_all("disarmed_spike");

    // Arm, then spike with exact pulse timing
    send(0, 1, 0, 0, 0, 0, 0, 0, 2);
    check_all("arm");
    is_reset_cmd = 0; is_arm_cmd = 0; is_cfg_cmd = 0; is_tick = 0;
    polarity = 0; addr = 6'h2A;
    strobe = 1'b1;
    @(negedge clk);                    // edge k has sampled the strobe
    chk("lat.k", int'(spike_valid), 0);
    @(negedge clk);                    // after edge k+1
    chk("lat.k1", int'(spike_valid), 0);
    @(negedge clk);                    // after edge k+2
    chk("lat.k2", int'(spike_valid), 1);
    chk("lat.addr", int'(spike_addr), 'h2A);
    chk("lat.pol", int'(spike_pol), 0);
    @(negedge clk);                    // after edge k+3
    chk("lat.k3", int'(spike_valid), 0);
    strobe = 1'b0;
    repeat (4) @(negedge clk);
    model_event(1, 0, 0, 0, 0, 0, 'h2A, 0, 0);
    check_all("armed_spike");

    // Reset cmd, then disarmed config writes
    send(1, 0, 0, 0, 0, 0, 0, 0, 2);
    check_all("reset_cmd1");
    send(0, 0, 1, 0, 0, 0, 0, 'h3, 2);
    send(0, 0, 1, 0, 0, 0, 1, 'hA, 2);
    send(0, 0, 1, 0, 0, 0, 2, 'h5, 2);
    check_all("cfg_write");
    chk("cfg.thr_a3", int'(cfg_threshold), 'hA3);

    // Armed config write is refused and flagged
    send(0, 1, 0, 0, 0, 0, 0, 0, 2);
    send(0, 0, 1, 0, 0, 0, 3, 'hF, 2);
    check_all("cfg_armed");
    chk("cfg_armed.err", int'(cfg_err), 1);
    send(1, 0, 0, 0, 0, 0, 0, 0, 2);
    check_all("reset_cmd2");
    chk("reset_cmd2.thr16", int'(cfg_threshold), 16);

    // Randomised events with overlapping flags
    for (int i = 0; i < 60; i++) begin
      send($urandom_range(0, 15) == 0, $urandom_range(0, 4) == 0,
           $urandom_range(0, 3) == 0, 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), int'($urandom_range(0, 63)),
           int'($urandom_range(0, 3)), int'($urandom_range(0, 15)),
           int'($urandom_range(1, 3)));
      check_all($sformatf("rand%0d", i));
    end

    // Saturation: 300 disarmed ticks after a reset cmd
    send(1, 0, 0, 0, 0, 0, 0, 0, 2);
    for (int i = 0; i < 300; i++) send(0, 0, 0, 1, 0, 0, 0, 0, 1);
    check_all("saturate");
    chk("saturate.drop", int'(drop_cnt), DROP_EN ? 255 : 0);

    // Held strobe produces one tick only
    send(0, 1, 0, 0, 0, 0, 0, 0, 2);
    send(0, 0, 0, 1, 0, 0, 0, 0, 20);
    check_all("held");

    // Enable low drops the edge entirely, even while disarmed
    send(1, 0, 0, 0, 0, 0, 0, 0, 2);
    ena = 1'b0;
    send(0, 0, 0, 0, 1, 9, 0, 0, 2);
    send(0, 1, 0, 0, 0, 0, 0, 0, 2);
    ena = 1'b1;
    check_all("ena_low");

    // Reset asserted one cycle after a strobe edge, strobe high across release
    send(0, 1, 0, 0, 0, 0, 0, 0, 2);
    is_reset_cmd = 0; is_arm_cmd = 0; is_cfg_cmd = 0; is_tick = 0;
    polarity = 1; addr = 6'h11;
    strobe = 1'b1;
    @(negedge clk);
    rst_n = 1'b0;
    model_hw_reset();
    @(negedge clk);
    check_all("mid_reset");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    check_all("post_reset_high");
    strobe = 1'b0;
    repeat (4) @(negedge clk);
    check_all("post_reset_low");
    send(0, 0, 0, 0, 1, 3, 0, 0, 2);
    check_all("recovery");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
